// File: rtl/serial_word_deserializer_if.sv
// Serial receive bus and parallel output buffer of the word deserializer.
// The master drives the serial side and the consumer ready; the slave is the deserializer.
interface serial_word_deserializer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             serial_in;
  logic             in_valid;
  logic             msb_first;
  logic             frame_sync;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output serial_in, in_valid, msb_first, frame_sync, out_ready,
    input  parallel_out, out_valid, busy, overrun, bit_cnt
  );

  modport slave (
    input  serial_in, in_valid, msb_first, frame_sync, out_ready,
    output parallel_out, out_valid, busy, overrun, bit_cnt
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Collects WIDTH serial bits (MSB- or LSB-first) into a word and hands it off
// through a single-entry valid/ready buffer with a sticky overrun flag.
module serial_word_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                         clk,
  input  logic                         clr,
  serial_word_deserializer_if.slave    sif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  logic [WIDTH-1:0] shift_q, shift_d, base_reg, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
  logic             dir_q, dir_d, dir, start, done, buf_free;
  logic [WIDTH-1:0] po_q;
  logic             ov_q, ovr_q;
  state_t           state;

  assign state = (cnt_q == '0) ? S_IDLE : S_COLLECT;

  // frame_sync restarts the word before the incoming bit is considered,
  // so a bit arriving on the same edge becomes bit 0 and latches direction.
  always_comb begin
    base_reg = shift_q;
    base_cnt = cnt_q;
    start    = (state == S_IDLE);
    if (sif.frame_sync) begin
      base_reg = '0;
      base_cnt = '0;
      start    = 1'b1;
    end
    dir     = start ? sif.msb_first : dir_q;
    shifted = dir ? {base_reg[WIDTH-2:0], sif.serial_in}
                  : {sif.serial_in, base_reg[WIDTH-1:1]};
    shift_d = base_reg;
    cnt_d   = base_cnt;
    dir_d   = dir_q;
    done    = 1'b0;
    if (sif.in_valid) begin
      shift_d = shifted;
      dir_d   = dir;
      if (base_cnt == LAST) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = base_cnt + 1'b1;
      end
    end
  end

  assign buf_free = !ov_q || sif.out_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      po_q    <= '0;
      ov_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      if (done && buf_free) begin
        po_q <= shifted;
        ov_q <= 1'b1;
      end else if (done) begin
        ovr_q <= 1'b1;
      end else if (ov_q && sif.out_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign sif.parallel_out = po_q;
  assign sif.out_valid    = ov_q;
  assign sif.overrun      = ovr_q;
  assign sif.bit_cnt      = cnt_q;
  assign sif.busy         = (state == S_COLLECT);

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Randomized and directed checks of serial_word_deserializer against a
// bit-queue reference model of the receive link.
module tb_serial_word_deserializer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   total = 0;
  int   bad   = 0;

  serial_word_deserializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

  serial_word_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .sif (sif)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of received bits plus the output buffer.
  bit             m_bits[$];
  bit             m_dir;
  logic [WIDTH-1:0] m_po;
  bit             m_ov, m_ovr;

  task automatic model_step(input bit c, fs, iv, si, msb, rdy);
    logic [WIDTH-1:0] w;
    bit done;
    if (c) begin
      m_bits.delete(); m_dir = 0; m_po = '0; m_ov = 0; m_ovr = 0;
      return;
    end
    done = 0;
    w = '0;
    if (fs) m_bits.delete();
    if (iv) begin
      if (m_bits.size() == 0) m_dir = msb;
      m_bits.push_back(si);
      if (m_bits.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++)
          if (m_dir) w[WIDTH-1-i] = m_bits[i];
          else       w[i]         = m_bits[i];
        m_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_ov || rdy) begin m_po = w; m_ov = 1; end
      else m_ovr = 1;
    end else if (m_ov && rdy) begin
      m_ov = 0;
    end
  endtask

  // Drive one cycle starting at a negedge; returns at the following negedge.
  task automatic cyc(input bit c, fs, iv, si, msb, rdy);
    clr = c; sif.frame_sync = fs; sif.in_valid = iv; sif.serial_in = si;
    sif.msb_first = msb; sif.out_ready = rdy;
    model_step(c, fs, iv, si, msb, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit msb, input bit rdy);
    logic [WIDTH-1:0] v;
    v = w;
    for (int i = 0; i < WIDTH; i++)
      cyc(0, 0, 1, msb ? v[WIDTH-1-i] : v[i], msb, rdy);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0);
    total++;
    if ({sif.parallel_out, sif.out_valid, sif.overrun, sif.busy, sif.bit_cnt} !== '0) begin
      bad++;
      $display("FAIL reset got po=%h ov=%b ovr=%b busy=%b cnt=%0d exp all zero",
               sif.parallel_out, sif.out_valid, sif.overrun, sif.busy, sif.bit_cnt);
    end
  endtask

  task automatic test_msb();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    total++;
    if (sif.busy !== 1'b1 || sif.bit_cnt !== 3'd1) begin
      bad++; $display("FAIL msb_busy got busy=%b cnt=%0d exp 1 1", sif.busy, sif.bit_cnt);
    end
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    total++;
    if (sif.out_valid !== 1'b0) begin
      bad++; $display("FAIL msb_early_valid got=%b exp=0", sif.out_valid);
    end
    cyc(0, 0, 1, 1, 1, 0);
    total++;
    if (sif.parallel_out !== 4'b1011 || sif.out_valid !== 1'b1 || sif.busy !== 1'b0) begin
      bad++; $display("FAIL msb_word got po=%b ov=%b busy=%b exp 1011 1 0",
                      sif.parallel_out, sif.out_valid, sif.busy);
    end
    cyc(0, 0, 0, 0, 0, 1);
    total++;
    if (sif.out_valid !== 1'b0 || sif.parallel_out !== 4'b1011) begin
      bad++; $display("FAIL msb_consume got ov=%b po=%b exp 0 1011", sif.out_valid, sif.parallel_out);
    end
  endtask

  task automatic test_lsb();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0, 0);
    total++;
    if (sif.parallel_out !== 4'b1101 || sif.out_valid !== 1'b1) begin
      bad++; $display("FAIL lsb_word got po=%b ov=%b exp 1101 1", sif.parallel_out, sif.out_valid);
    end
  endtask

  task automatic test_overrun();
    cyc(1, 0, 0, 0, 0, 0);
    send_word(4'hA, 1, 0);
    total++;
    if (sif.overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_early got=%b exp=0", sif.overrun);
    end
    send_word(4'h5, 1, 0);
    total++;
    if (sif.parallel_out !== 4'hA || sif.overrun !== 1'b1 || sif.bit_cnt !== 3'd0
        || sif.out_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_drop got po=%h ovr=%b cnt=%0d ov=%b exp a 1 0 1",
                      sif.parallel_out, sif.overrun, sif.bit_cnt, sif.out_valid);
    end
    send_word(4'h3, 1, 1);
    total++;
    if (sif.overrun !== 1'b1 || sif.parallel_out !== 4'h3) begin
      bad++; $display("FAIL ovr_sticky got ovr=%b po=%h exp 1 3", sif.overrun, sif.parallel_out);
    end
  endtask

  task automatic test_frame_sync();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 1, 0);
    total++;
    if (sif.bit_cnt !== 3'd1) begin
      bad++; $display("FAIL fsync_cnt got=%0d exp=1", sif.bit_cnt);
    end
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    total++;
    if (sif.parallel_out !== 4'b0110 || sif.overrun !== 1'b0 || sif.out_valid !== 1'b1) begin
      bad++; $display("FAIL fsync_word got po=%b ovr=%b ov=%b exp 0110 0 1",
                      sif.parallel_out, sif.overrun, sif.out_valid);
    end
  endtask

  task automatic test_clr_mid();
    send_word(4'h9, 1, 1);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(1, 0, 1, 1, 1, 1);
    total++;
    if ({sif.parallel_out, sif.out_valid, sif.overrun, sif.busy, sif.bit_cnt} !== '0) begin
      bad++; $display("FAIL clr_mid got po=%h ov=%b ovr=%b busy=%b cnt=%0d exp all zero",
                      sif.parallel_out, sif.out_valid, sif.overrun, sif.busy, sif.bit_cnt);
    end
    send_word(4'b0011, 1, 0);
    total++;
    if (sif.parallel_out !== 4'b0011 || sif.out_valid !== 1'b1) begin
      bad++; $display("FAIL clr_word got po=%b ov=%b exp 0011 1", sif.parallel_out, sif.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 0, 0, 0, 0);
    send_word(4'h6, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 1);
    total++;
    if (sif.parallel_out !== 4'hC || sif.out_valid !== 1'b1 || sif.overrun !== 1'b0) begin
      bad++; $display("FAIL b2b got po=%h ov=%b ovr=%b exp c 1 0",
                      sif.parallel_out, sif.out_valid, sif.overrun);
    end
  endtask

  task automatic test_random();
    logic [WIDTH+CNT_W+2:0] got, exp;
    cyc(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(99) < 2, $urandom_range(99) < 6, $urandom_range(99) < 70,
          1'($urandom), 1'($urandom), $urandom_range(99) < 40);
      got = {sif.parallel_out, sif.out_valid, sif.overrun, sif.busy, sif.bit_cnt};
      exp = {m_po, m_ov, m_ovr, m_bits.size() != 0, CNT_W'(m_bits.size())};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h (po,ov,ovr,busy,cnt)", n, got, exp);
      end
    end
  endtask

  initial begin
    sif.serial_in = 0; sif.in_valid = 0; sif.msb_first = 0;
    sif.frame_sync = 0; sif.out_ready = 0;
    @(negedge clk);
    test_reset();
    test_msb();
    test_lsb();
    test_overrun();
    test_frame_sync();
    test_clr_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
